// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes the bit clock, WS and data into clk, deserializes
// MSB-first slots and delivers left/right pairs through a valid/ready handshake.
module i2s_rx #(
    parameter int unsigned NUM_BITS_DAC = 24,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_clk,
    input  logic                    word_select,
    input  logic                    serial_data,
    output logic [NUM_BITS_DAC-1:0] left_out,
    output logic [NUM_BITS_DAC-1:0] right_out,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    overrun,
    output logic                    frame_err
);

    localparam int unsigned CntW = $clog2(NUM_BITS_DAC + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(NUM_BITS_DAC);
    localparam logic [CntW-1:0] CntLast = CntW'(NUM_BITS_DAC - 1);

    typedef enum logic {StSeek, StRun} state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]  ws_sync_q, ws_sync_d;
    logic [SYNC_STAGES-1:0]  sd_sync_q, sd_sync_d;
    logic                    sclk_prev_q, sclk_prev_d;
    logic                    ws_prev_q, ws_prev_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [NUM_BITS_DAC-1:0] shift_q, shift_d;
    logic [NUM_BITS_DAC-1:0] left_hold_q, left_hold_d;
    logic [NUM_BITS_DAC-1:0] right_hold_q, right_hold_d;
    logic [NUM_BITS_DAC-1:0] left_out_q, left_out_d;
    logic [NUM_BITS_DAC-1:0] right_out_q, right_out_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic                    frame_err_q, frame_err_d;

    logic                    sclk_s, ws_s, sd_s, rise, frame_done;
    logic [NUM_BITS_DAC-1:0] word;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign ws_s   = ws_sync_q[SYNC_STAGES-1];
    assign sd_s   = sd_sync_q[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_prev_q;

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], s_clk};
        ws_sync_d    = {ws_sync_q[SYNC_STAGES-2:0], word_select};
        sd_sync_d    = {sd_sync_q[SYNC_STAGES-2:0], serial_data};
        sclk_prev_d  = sclk_s;
        state_d      = state_q;
        ws_prev_d    = ws_prev_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        left_hold_d  = left_hold_q;
        right_hold_d = right_hold_q;
        left_out_d   = left_out_q;
        right_out_d  = right_out_q;
        valid_d      = valid_q;
        overrun_d    = 1'b0;
        frame_err_d  = 1'b0;
        frame_done   = 1'b0;

        // Current shift contents with this rise's bit merged in, if room remains.
        word = shift_q;
        if (cnt_q < CntMax) begin
            word[CntLast - cnt_q] = sd_s;
        end

        if (rise) begin
            ws_prev_d = ws_s;
            case (state_q)
                StSeek: begin
                    if (ws_prev_q && !ws_s) begin
                        state_d = StRun;
                        cnt_d   = '0;
                        shift_d = '0;
                    end
                end
                StRun: begin
                    if (ws_s != ws_prev_q) begin
                        // Short slot: unwritten LSBs are already zero from the clear.
                        frame_err_d = (cnt_q < CntLast);
                        if (ws_prev_q) begin
                            right_hold_d = word;
                            frame_done   = 1'b1;
                        end else begin
                            left_hold_d = word;
                        end
                        cnt_d   = '0;
                        shift_d = '0;
                    end else begin
                        shift_d = word;
                        if (cnt_q < CntMax) begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
                default: state_d = StSeek;
            endcase
        end

        if (frame_done) begin
            left_out_d  = left_hold_q;
            right_out_d = word;
            valid_d     = 1'b1;
            overrun_d   = valid_q & ~sample_ready;
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StSeek;
            sclk_sync_q  <= '0;
            ws_sync_q    <= '0;
            sd_sync_q    <= '0;
            sclk_prev_q  <= 1'b0;
            ws_prev_q    <= 1'b0;
            cnt_q        <= '0;
            shift_q      <= '0;
            left_hold_q  <= '0;
            right_hold_q <= '0;
            left_out_q   <= '0;
            right_out_q  <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= sclk_sync_d;
            ws_sync_q    <= ws_sync_d;
            sd_sync_q    <= sd_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            ws_prev_q    <= ws_prev_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            left_hold_q  <= left_hold_d;
            right_hold_q <= right_hold_d;
            left_out_q   <= left_out_d;
            right_out_q  <= right_out_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign left_out     = left_out_q;
    assign right_out    = right_out_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign frame_err    = frame_err_q;

endmodule
